// File: rtl/apb4_reg_array_pkg.sv
// apb4_reg_array_pkg
//   Shared types and helpers for the APB4 register array:
//   - state_e      : transfer FSM states
//   - decode_t     : result of an address decode {hit, index}
//   - decode_addr  : byte address -> {hit, index} for a base/stride/count map
//   - strb_to_mask : APB byte strobes -> 32-bit bit-enable mask
package apb4_reg_array_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RD_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic       hit;
      logic [7:0] idx;
   } decode_t;

   // Address bits [1:0] are dropped before decoding. Arithmetic is done in
   // 40 bits so base + count*stride cannot wrap.
   function automatic decode_t decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] n_regs);
      logic [39:0] a;
      logic [39:0] b;
      logic [39:0] off;
      logic [39:0] span;
      decode_t     d;
      a     = {8'd0, addr[31:2], 2'b00};
      b     = {8'd0, base};
      off   = a - b;
      span  = 40'(n_regs) * 40'(stride);
      d.hit = (a >= b) && (off < span) && ((off & (40'(stride) - 40'd1)) == 40'd0);
      d.idx = 8'(off / 40'(stride));
      return d;
   endfunction

   function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int unsigned i = 0; i < 4; i++) begin
         m[i*8 +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/apb4_reg_array_field.sv
// apb4_reg_array_field
//   Storage for one register field with software/hardware write merge.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     sw_we               software write commits this cycle
//     sw_mask, sw_wdata   per-bit software enable and data
//     hw_we, hw_wdata     hardware write enable and data
//     value               current field contents
//     anded               AND-reduction of the field (combinational)
//     swmod               one-cycle pulse after a software write touching the field
module apb4_reg_array_field #(
   parameter int unsigned        FIELD_W   = 8,
   parameter logic [FIELD_W-1:0] RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sw_we,
   input  logic [FIELD_W-1:0] sw_mask,
   input  logic [FIELD_W-1:0] sw_wdata,
   input  logic               hw_we,
   input  logic [FIELD_W-1:0] hw_wdata,
   output logic [FIELD_W-1:0] value,
   output logic               anded,
   output logic               swmod
);

   logic [FIELD_W-1:0] value_d, value_q;
   logic [FIELD_W-1:0] merge_base;
   logic               swmod_d, swmod_q;

   // Hardware data forms the base; software overrides only strobed bits.
   always_comb begin
      merge_base = hw_we ? hw_wdata : value_q;
      value_d    = merge_base;
      swmod_d    = 1'b0;
      if (sw_we) begin
         value_d = (sw_wdata & sw_mask) | (merge_base & ~sw_mask);
         swmod_d = |sw_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= RESET_VAL;
         swmod_q <= 1'b0;
      end else begin
         value_q <= value_d;
         swmod_q <= swmod_d;
      end
   end

   assign value = value_q;
   assign anded = &value_q;
   assign swmod = swmod_q;

endmodule

// File: rtl/apb4_reg_array.sv
// apb4_reg_array
//   APB4 slave exposing N_REGS single-field registers at BASE_ADDR + i*STRIDE.
//   Ports:
//     clk, rst                       clock, asynchronous active-high reset
//     s_apb_*                        APB4 slave (pready/prdata/pslverr registered)
//     hwif_in_we / hwif_in_wdata     per-register hardware write
//     hwif_out_value                 field storage, register i at [i*FIELD_W +: FIELD_W]
//     hwif_out_anded                 AND-reduction per field
//     hwif_out_swmod                 software-modify pulse per register
module apb4_reg_array
   import apb4_reg_array_pkg::*;
#(
   parameter int unsigned N_REGS    = 112,
   parameter int unsigned FIELD_W   = 8,
   parameter logic [31:0] RESET_VAL = 32'h10,
   parameter logic [31:0] BASE_ADDR = 32'h200,
   parameter int unsigned STRIDE    = 8,
   parameter int unsigned ADDR_W    = 11
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_apb_psel,
   input  logic                        s_apb_penable,
   input  logic                        s_apb_pwrite,
   input  logic [ADDR_W-1:0]           s_apb_paddr,
   input  logic [31:0]                 s_apb_pwdata,
   input  logic [3:0]                  s_apb_pstrb,
   output logic                        s_apb_pready,
   output logic [31:0]                 s_apb_prdata,
   output logic                        s_apb_pslverr,
   input  logic [N_REGS-1:0]           hwif_in_we,
   input  logic [N_REGS*FIELD_W-1:0]   hwif_in_wdata,
   output logic [N_REGS*FIELD_W-1:0]   hwif_out_value,
   output logic [N_REGS-1:0]           hwif_out_anded,
   output logic [N_REGS-1:0]           hwif_out_swmod
);

   state_e             state_d, state_q;
   logic               pwrite_d, pwrite_q;
   logic               hit_d, hit_q;
   logic [7:0]         idx_d, idx_q;
   logic [FIELD_W-1:0] wdata_d, wdata_q;
   logic [FIELD_W-1:0] mask_d, mask_q;
   logic               pready_d, pready_q;
   logic               pslverr_d, pslverr_q;
   logic [31:0]        prdata_d, prdata_q;
   decode_t            dec;
   logic [FIELD_W-1:0] rd_field;
   logic               sw_commit;

   // Decode happens at setup so pready can already be high in the first
   // access cycle for writes and errors.
   always_comb begin
      state_d   = state_q;
      pwrite_d  = pwrite_q;
      hit_d     = hit_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      mask_d    = mask_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      dec       = decode_addr(32'(s_apb_paddr), BASE_ADDR, 32'(STRIDE), 32'(N_REGS));
      unique case (state_q)
         ST_IDLE: begin
            if (s_apb_psel && !s_apb_penable) begin
               pwrite_d  = s_apb_pwrite;
               hit_d     = dec.hit;
               idx_d     = dec.idx;
               wdata_d   = FIELD_W'(s_apb_pwdata);
               mask_d    = FIELD_W'(strb_to_mask(s_apb_pstrb));
               pready_d  = s_apb_pwrite || !dec.hit;
               pslverr_d = !dec.hit;
               state_d   = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (hit_q && !pwrite_q) begin
               pready_d = 1'b1;
               prdata_d = 32'(rd_field);
               state_d  = ST_RD_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_RESP: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pwrite_q  <= 1'b0;
         hit_q     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         pwrite_q  <= pwrite_d;
         hit_q     <= hit_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         mask_q    <= mask_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign sw_commit = (state_q == ST_ACCESS) && pwrite_q && hit_q;

   always_comb begin
      rd_field = '0;
      for (int unsigned i = 0; i < N_REGS; i++) begin
         rd_field = rd_field |
                    (hwif_out_value[i*FIELD_W +: FIELD_W] & {FIELD_W{idx_q == 8'(i)}});
      end
   end

   for (genvar g = 0; g < N_REGS; g++) begin : g_field
      apb4_reg_array_field #(
         .FIELD_W   (FIELD_W),
         .RESET_VAL (RESET_VAL[FIELD_W-1:0])
      ) u_field (
         .clk      (clk),
         .rst      (rst),
         .sw_we    (sw_commit && (idx_q == 8'(g))),
         .sw_mask  (mask_q),
         .sw_wdata (wdata_q),
         .hw_we    (hwif_in_we[g]),
         .hw_wdata (hwif_in_wdata[g*FIELD_W +: FIELD_W]),
         .value    (hwif_out_value[g*FIELD_W +: FIELD_W]),
         .anded    (hwif_out_anded[g]),
         .swmod    (hwif_out_swmod[g])
      );
   end

   assign s_apb_pready  = pready_q;
   assign s_apb_pslverr = pslverr_q;
   assign s_apb_prdata  = prdata_q;

endmodule

// File: tb/tb_apb4_reg_array.sv
module tb_apb4_reg_array;

   localparam int N      = 112;
   localparam int W      = 8;
   localparam int BASE   = 'h200;
   localparam int STRIDE = 8;
   localparam logic [W-1:0] RST_VAL = 8'h10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [10:0]     paddr = '0;
   logic [31:0]     pwdata = '0;
   logic [3:0]      pstrb = '0;
   logic            pready, pslverr;
   logic [31:0]     prdata;
   logic [N-1:0]    hw_we = '0;
   logic [N*W-1:0]  hw_wd = '0;
   logic [N*W-1:0]  value;
   logic [N-1:0]    anded, swmod;

   // Narrow instance with 16-bit fields sharing the same bus.
   logic [63:0]     value16;
   logic [3:0]      anded16, swmod16;
   logic            pready16, pslverr16;
   logic [31:0]     prdata16;
   logic [3:0]      hw_we16 = '0;
   logic [63:0]     hw_wd16 = '0;

   always #5 clk = ~clk;

   apb4_reg_array #(
      .N_REGS(N), .FIELD_W(W), .RESET_VAL(32'h10), .BASE_ADDR(32'h200),
      .STRIDE(STRIDE), .ADDR_W(11)
   ) u_dut (
      .clk(clk), .rst(rst),
      .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
      .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
      .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
      .hwif_in_we(hw_we), .hwif_in_wdata(hw_wd),
      .hwif_out_value(value), .hwif_out_anded(anded), .hwif_out_swmod(swmod)
   );

   apb4_reg_array #(
      .N_REGS(4), .FIELD_W(16), .RESET_VAL(32'h10), .BASE_ADDR(32'h200),
      .STRIDE(STRIDE), .ADDR_W(11)
   ) u_dut16 (
      .clk(clk), .rst(rst),
      .s_apb_psel(psel), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
      .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb),
      .s_apb_pready(pready16), .s_apb_prdata(prdata16), .s_apb_pslverr(pslverr16),
      .hwif_in_we(hw_we16), .hwif_in_wdata(hw_wd16),
      .hwif_out_value(value16), .hwif_out_anded(anded16), .hwif_out_swmod(swmod16)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: one array entry per register, updated once per clock edge.
   logic [W-1:0]  mdl [N];
   logic [N-1:0]  exp_swmod = '0;
   bit            commit_pend = 0;
   int unsigned   commit_idx = 0;
   logic [31:0]   commit_data = '0;
   logic [3:0]    commit_strb = '0;
   bit            hw_rand_en = 0;
   bit            hw_nx_valid = 0;
   logic [N-1:0]  hw_nx_we = '0;
   logic [N*W-1:0] hw_nx_wd = '0;

   function automatic bit ref_hit(input int unsigned addr, output int unsigned idx);
      int unsigned a;
      a   = addr & ~32'd3;
      idx = 0;
      if (a < BASE) return 0;
      if (a - BASE >= N * STRIDE) return 0;
      if ((a - BASE) % STRIDE != 0) return 0;
      idx = (a - BASE) / STRIDE;
      return 1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) mdl[i] = RST_VAL;
      exp_swmod   = '0;
      commit_pend = 0;
   endtask

   task automatic model_edge();
      exp_swmod = '0;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < N; i++)
         if (hw_we[i]) mdl[i] = hw_wd[i*W +: W];
      if (commit_pend) begin
         for (int b = 0; b < W; b++)
            if (commit_strb[b/8]) mdl[commit_idx][b] = commit_data[b];
         for (int k = 0; k < 4; k++)
            if (commit_strb[k] && (k * 8 < W)) exp_swmod[commit_idx] = 1'b1;
         commit_pend = 0;
      end
   endtask

   task automatic check_state();
      for (int i = 0; i < N; i++) begin
         check_eq("value", 32'(value[i*W +: W]), 32'(mdl[i]));
         check_eq("anded", 32'(anded[i]), 32'(&mdl[i]));
         check_eq("swmod", 32'(swmod[i]), 32'(exp_swmod[i]));
      end
   endtask

   // Called at a falling edge; advances to the next falling edge.
   task automatic step();
      if (hw_nx_valid) begin
         hw_we       = hw_nx_we;
         hw_wd       = hw_nx_wd;
         hw_nx_valid = 0;
      end else if (hw_rand_en) begin
         for (int i = 0; i < N; i++) begin
            hw_we[i]         = ($urandom_range(0, 15) == 0);
            hw_wd[i*W +: W]  = W'($urandom);
         end
      end else begin
         hw_we = '0;
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_state();
   endtask

   task automatic apb_xfer(input bit wr, input logic [10:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input bit t1_hw, output logic [31:0] rdata);
      int unsigned idx;
      bit          hit;
      logic [31:0] exp_rd;
      hit   = ref_hit(32'(addr), idx);
      rdata = '0;
      check_eq("idle_pready", 32'(pready), 32'd0);
      check_eq("idle_pslverr", 32'(pslverr), 32'd0);
      check_eq("idle_prdata", prdata, 32'd0);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
      step();
      penable = 1'b1;
      if (t1_hw) hw_nx_valid = 1;
      if (wr || !hit) begin
         if (wr && hit) begin
            commit_pend = 1; commit_idx = idx; commit_data = wd; commit_strb = strb;
         end
         check_eq("t1_pready", 32'(pready), 32'd1);
         check_eq("t1_pslverr", 32'(pslverr), 32'(!hit));
         check_eq("t1_prdata", prdata, 32'd0);
         step();
      end else begin
         check_eq("rd_wait_pready", 32'(pready), 32'd0);
         exp_rd = 32'(mdl[idx]);
         step();
         check_eq("rd_pready", 32'(pready), 32'd1);
         check_eq("rd_pslverr", 32'(pslverr), 32'd0);
         check_eq("rd_prdata", prdata, exp_rd);
         rdata = prdata;
         step();
      end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic reset_mid(input bit wr, input logic [10:0] addr, input logic [31:0] wd);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = 4'hF;
      step();
      penable = 1'b1;
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("rst_pready", 32'(pready), 32'd0);
      check_eq("rst_pslverr", 32'(pslverr), 32'd0);
      check_eq("rst_prdata", prdata, 32'd0);
      check_state();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge clk);
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      model_reset();
      for (int i = 0; i < 3; i++) step();
      rst = 1'b0;
      check_eq("rst_pready0", 32'(pready), 32'd0);
      check_eq("rst_v16", 32'(value16[15:0]), 32'h10);

      apb_xfer(0, 11'h578, 32'h0, 4'h0, 0, rd);
      check_eq("rd_578", rd, 32'h0000_0010);

      apb_xfer(1, 11'h200, 32'h0000_ABCD, 4'h2, 0, rd);
      check_eq("fw16_strb2", 32'(value16[15:0]), 32'h0000_AB10);

      apb_xfer(1, 11'h200, 32'h0000_00FF, 4'h1, 0, rd);
      check_eq("wr200_value", 32'(value[7:0]), 32'hFF);
      check_eq("wr200_anded", 32'(anded[0]), 32'd1);
      apb_xfer(0, 11'h200, 32'h0, 4'h0, 0, rd);
      check_eq("rd200", rd, 32'h0000_00FF);

      apb_xfer(1, 11'h208, 32'h0000_00AB, 4'h0, 0, rd);
      check_eq("strb0_value", 32'(value[15:8]), 32'h10);

      apb_xfer(1, 11'h204, 32'h0000_0077, 4'hF, 0, rd);
      apb_xfer(0, 11'h204, 32'h0, 4'h0, 0, rd);
      apb_xfer(1, 11'h580, 32'h0000_0077, 4'hF, 0, rd);
      apb_xfer(0, 11'h580, 32'h0, 4'h0, 0, rd);

      hw_nx_we = '0;
      hw_nx_wd = '0;
      hw_nx_we[5] = 1'b1; hw_nx_we[6] = 1'b1;
      hw_nx_wd[5*W +: W] = 8'h55;
      hw_nx_wd[6*W +: W] = 8'h55;
      apb_xfer(1, 11'h228, 32'h0000_0066, 4'h1, 1, rd);
      check_eq("same_edge_v5", 32'(value[5*W +: W]), 32'h66);
      check_eq("same_edge_v6", 32'(value[6*W +: W]), 32'h55);

      hw_rand_en = 1;
      for (int t = 0; t < 300; t++) begin
         int unsigned sel, ridx, a;
         sel  = $urandom_range(0, 9);
         ridx = $urandom_range(0, N - 1);
         if (sel < 6)       a = BASE + ridx * STRIDE + $urandom_range(0, 3);
         else if (sel < 8)  a = BASE + ridx * STRIDE + 4 + $urandom_range(0, 3);
         else if (sel == 8) a = BASE + N * STRIDE + $urandom_range(0, 'h7FF - (BASE + N * STRIDE));
         else               a = $urandom_range(0, 'h7FF);
         apb_xfer($urandom_range(0, 1) == 1, 11'(a), $urandom, 4'($urandom), 0, rd);
      end
      hw_rand_en = 0;

      reset_mid(0, 11'h210, 32'h0);
      reset_mid(1, 11'h218, 32'h0000_0033);
      apb_xfer(1, 11'h210, 32'h0000_005A, 4'hF, 0, rd);
      apb_xfer(0, 11'h210, 32'h0, 4'h0, 0, rd);
      check_eq("post_rst_rd", rd, 32'h0000_005A);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
